// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use bubble, branch/jump flush, memory-busy freeze with timeout.
// Latency: all control outputs are combinational from current state + ID/EX/MEM inputs (0 cycles).
// Backpressure: mem_busy freezes PC and every pipeline register; a stuck memory latches ERROR until reset.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 3,
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  input  logic              mem_busy,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_hold,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  // wait_cnt must be able to hold WAIT_MAX itself, since the timeout fires
  // on the busy cycle that finds the counter already at WAIT_MAX.
  localparam int WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;
  logic           timeout_set;

  logic           rs_hit;
  logic           rt_hit;
  logic           load_use;
  logic           redirect;
  logic           hold_cond;
  logic           count_en;

  // Hazard detection terms; r0 is never a real producer so it cannot create a load-use.
  always_comb begin
    rs_hit    = id_uses_rs && (id_rs == ex_rd);
    rt_hit    = id_uses_rt && (id_rt == ex_rd);
    load_use  = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);
    redirect  = ex_branch_taken || ex_jump;
    hold_cond = (state == ST_ERROR) ||
                (mem_busy && ((state == ST_RUN) || (state == ST_WAIT)));
  end

  // Output priority: memory freeze, then control-flow flush, then load-use bubble, else advance.
  always_comb begin
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (state == ST_INIT) begin
      // Keep the front end parked and the ID/EX control zeroed until the first live cycle.
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (hold_cond) begin
      // Nothing moves and no bubble is injected, so EX/MEM is preserved intact.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (redirect) begin
      // The ID instruction is wrong-path, so any load-use it shows is irrelevant.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // One bubble: next cycle the bubble occupies EX and the load has moved on.
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  // Next-state logic: track consecutive busy cycles and trip to ERROR past WAIT_MAX.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    case (state)
      ST_INIT: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
      ST_RUN: begin
        if (mem_busy) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = WAIT_ONE;
        end
      end
      ST_WAIT: begin
        if (!mem_busy) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt >= WAIT_LIM) begin
          state_nxt   = ST_ERROR;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_ONE;
        end
      end
      ST_ERROR: begin
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt    = ST_INIT;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // State and busy-length register; reset drops straight to INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout <= 1'b0;
    end else if (timeout_set) begin
      mem_timeout <= 1'b1;
    end
  end

  // Performance counter of lost cycles; INIT cycles are excluded and the count saturates.
  always_comb begin
    count_en = (state != ST_INIT) && (stall || pipe_hold) && (stall_cycles != '1);
  end

  // Saturating stall/hold cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (count_en) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule
